// File: rtl/wb_pipe.sv
// Write-back stage: commits ALU/load results to the register file, keeps
// a short history of committed writes for forwarding, counts retirements.
//
// Ports:
//   clk, reset        sole clock, synchronous active-high reset
//   delay, flush      stall (hold everything) / discard in-flight and history
//   ma_*              memory-access stage result bundle
//   wb_valid/dest/data registered register-file write port
//   fwd_addr          forwarding query address
//   fwd_hit/fwd_data  combinational forwarding answer from history
//   retire_count      number of committed register writes (wraps)
module wb_pipe #(
  parameter int DATA_W     = 32,
  parameter int DEST_W     = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              delay,
  input  logic              flush,
  input  logic              ma_valid,
  input  logic [3:0]        ma_opcode,
  input  logic [1:0]        ma_size,
  input  logic [DEST_W-1:0] ma_dest,
  input  logic [DATA_W-1:0] ma_answer,
  input  logic [DATA_W-1:0] ma_mem_answer,
  output logic              wb_valid,
  output logic [DEST_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_data,
  input  logic [DEST_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retire_count
);

  logic              isWriteOp;
  logic              commitNow;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] writeData;

  logic              histValid [HIST_DEPTH];
  logic [DEST_W-1:0] histDest  [HIST_DEPTH];
  logic [DATA_W-1:0] histData  [HIST_DEPTH];

  // Opcodes 1001..1111 are non-writing classes.
  assign isWriteOp = !ma_opcode[3] || (ma_opcode == 4'b1000);

  assign commitNow = !delay && !flush && ma_valid
                   && (ma_dest != '0) && isWriteOp;

  always_comb begin
    loadData = ma_mem_answer;
    unique case (ma_size)
      2'b00: loadData = ma_mem_answer;
      2'b01: loadData = {{(DATA_W-8){ma_mem_answer[7]}},
                         ma_mem_answer[7:0]};
      2'b10: loadData = {{(DATA_W-16){ma_mem_answer[15]}},
                         ma_mem_answer[15:0]};
      2'b11: loadData = {{(DATA_W-8){1'b0}},
                         ma_mem_answer[7:0]};
      default: loadData = ma_mem_answer;
    endcase
  end

  assign writeData = ma_opcode[3] ? loadData : ma_answer;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_dest      <= '0;
      wb_data      <= '0;
      retire_count <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        histValid[i] <= 1'b0;
        histDest[i]  <= '0;
        histData[i]  <= '0;
      end
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        histValid[i] <= 1'b0;
      end
    end else if (!delay) begin
      wb_valid <= commitNow;
      wb_dest  <= commitNow ? ma_dest : '0;
      wb_data  <= commitNow ? writeData : '0;
      // History only moves on a commit; idle cycles keep it intact.
      if (commitNow) begin
        for (int i = HIST_DEPTH - 1; i >= 1; i--) begin
          histValid[i] <= histValid[i-1];
          histDest[i]  <= histDest[i-1];
          histData[i]  <= histData[i-1];
        end
        histValid[0] <= 1'b1;
        histDest[0]  <= ma_dest;
        histData[0]  <= writeData;
        retire_count <= retire_count + 32'd1;
      end
    end
  end

  // Scan oldest to newest so the newest match overwrites older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (histValid[i] && (histDest[i] == fwd_addr)
          && (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = histData[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe.sv
// Scoreboard bench for wb_pipe: directed cases plus random traffic
// against a queue-based reference model of the write-back rules.
module tb_wb_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int HD = 2;

  logic          clk;
  logic          reset;
  logic          delay;
  logic          flush;
  logic          ma_valid;
  logic [3:0]    ma_opcode;
  logic [1:0]    ma_size;
  logic [AW-1:0] ma_dest;
  logic [DW-1:0] ma_answer;
  logic [DW-1:0] ma_mem_answer;
  logic          wb_valid;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [31:0]   retire_count;

  wb_pipe #(.DATA_W(DW), .DEST_W(AW), .HIST_DEPTH(HD)) dut (
    .clk(clk), .reset(reset), .delay(delay), .flush(flush),
    .ma_valid(ma_valid), .ma_opcode(ma_opcode), .ma_size(ma_size),
    .ma_dest(ma_dest), .ma_answer(ma_answer),
    .ma_mem_answer(ma_mem_answer),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } hent_t;

  typedef struct {
    logic          valid;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic [31:0]   count;
    logic          hit;
    logic [DW-1:0] fdata;
  } exp_t;

  hent_t hist[$];
  exp_t  expQ[$];
  logic          mValid;
  logic [AW-1:0] mDest;
  logic [DW-1:0] mData;
  logic [31:0]   mCount;

  int passCnt = 0;
  int totalCnt = 0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endfunction

  function automatic logic [DW-1:0] extend(logic [1:0] sz,
                                           logic [DW-1:0] m);
    int unsigned b, h;
    b = m & 32'hFF;
    h = m & 32'hFFFF;
    case (sz)
      2'd0: return m;
      2'd1: return (b >= 128) ? DW'(b + 32'hFFFF_FF00) : DW'(b);
      2'd2: return (h >= 32768) ? DW'(h + 32'hFFFF_0000) : DW'(h);
      default: return DW'(b);
    endcase
  endfunction

  task automatic step(input logic rst, input logic fl, input logic dl,
                      input logic v, input logic [3:0] op,
                      input logic [1:0] sz, input logic [AW-1:0] d,
                      input logic [DW-1:0] ans, input logic [DW-1:0] mem,
                      input logic [AW-1:0] fa);
    exp_t e;
    hent_t n;
    bit writes;
    @(negedge clk);
    reset = rst; flush = fl; delay = dl; ma_valid = v;
    ma_opcode = op; ma_size = sz; ma_dest = d;
    ma_answer = ans; ma_mem_answer = mem; fwd_addr = fa;
    if (rst) begin
      mValid = 0; mDest = 0; mData = 0; mCount = 0;
      hist.delete();
    end else if (fl) begin
      mValid = 0; mDest = 0; mData = 0;
      hist.delete();
    end else if (!dl) begin
      writes = v && (d != 0) && (op <= 4'd8);
      if (writes) begin
        mValid = 1; mDest = d;
        mData = (op == 4'd8) ? extend(sz, mem) : ans;
        n.dest = d; n.data = mData;
        hist.push_front(n);
        if (hist.size() > HD) void'(hist.pop_back());
        mCount = mCount + 1;
      end else begin
        mValid = 0; mDest = 0; mData = 0;
      end
    end
    e.valid = mValid; e.dest = mDest; e.data = mData;
    e.count = mCount; e.hit = 0; e.fdata = 0;
    if (fa != 0) begin
      foreach (hist[i]) begin
        if (hist[i].dest == fa) begin
          e.hit = 1; e.fdata = hist[i].data;
          break;
        end
      end
    end
    expQ.push_back(e);
  endtask

  task automatic alu(input logic [AW-1:0] d, input logic [DW-1:0] a,
                     input logic [AW-1:0] fa);
    step(0, 0, 0, 1, 4'b0010, 2'b00, d, a, 32'hDEAD_BEEF, fa);
  endtask

  task automatic ld(input logic [1:0] sz, input logic [DW-1:0] m,
                    input logic [AW-1:0] fa);
    step(0, 0, 0, 1, 4'b1000, sz, 5'd9, 32'h1111_1111, m, fa);
  endtask

  // Monitor: one output set per clock, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        chk("wb_valid", 64'(wb_valid), 64'(e.valid));
        chk("wb_dest", 64'(wb_dest), 64'(e.dest));
        chk("wb_data", 64'(wb_data), 64'(e.data));
        chk("retire_count", 64'(retire_count), 64'(e.count));
        chk("fwd_hit", 64'(fwd_hit), 64'(e.hit));
        chk("fwd_data", 64'(fwd_data), 64'(e.fdata));
      end
    end
  end

  initial begin
    int unsigned r;
    logic [3:0] op;
    reset = 1; flush = 0; delay = 0; ma_valid = 0;
    ma_opcode = 0; ma_size = 0; ma_dest = 0;
    ma_answer = 0; ma_mem_answer = 0; fwd_addr = 0;

    step(1, 0, 0, 1, 4'b0010, 0, 5'd3, 32'h55, 0, 5'd3);
    step(1, 1, 1, 1, 4'b0010, 0, 5'd3, 32'h55, 0, 5'd3);
    // ALU write then forwarding of it
    alu(5'd3, 32'h0000_1234, 5'd3);
    // load sizes
    ld(2'b01, 32'h0000_0080, 5'd9);
    ld(2'b11, 32'h0000_0080, 5'd9);
    ld(2'b10, 32'h0000_8001, 5'd9);
    ld(2'b00, 32'hCAFE_8081, 5'd9);
    ld(2'b01, 32'h1234_567F, 5'd9);
    // stall with valid inputs, then release
    alu(5'd5, 32'd7, 5'd5);
    repeat (3) step(0, 0, 1, 1, 4'b0001, 0, 5'd8, 32'd99, 0, 5'd8);
    alu(5'd8, 32'd99, 5'd8);
    // history order
    alu(5'd4, 32'd1, 5'd4);
    alu(5'd4, 32'd2, 5'd4);
    alu(5'd6, 32'd3, 5'd4);
    alu(5'd7, 32'd9, 5'd4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6);
    // non-writing opcode, zero dest, zero query
    step(0, 0, 0, 1, 4'b1001, 0, 5'd2, 32'd5, 32'd5, 5'd7);
    step(0, 0, 0, 1, 4'b0001, 0, 5'd0, 32'd5, 32'd5, 5'd0);
    step(0, 0, 0, 1, 4'b1111, 0, 5'd7, 32'd5, 32'd5, 5'd7);
    // flush with stall and valid input
    step(0, 1, 1, 1, 4'b0010, 0, 5'd7, 32'd5, 32'd5, 5'd7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6);
    // reset after ten commits
    for (int i = 1; i <= 10; i++) alu(AW'(i), DW'(i * 3), AW'(i));
    step(1, 0, 0, 1, 4'b0010, 0, 5'd3, 32'd1, 0, 5'd10);
    alu(5'd3, 32'hABCD, 5'd3);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      op = (r < 70) ? 4'($urandom_range(0, 7))
         : (r < 90) ? 4'b1000 : 4'($urandom_range(9, 15));
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 85,
           op, 2'($urandom_range(0, 3)),
           AW'($urandom_range(0, 7)),
           $urandom, $urandom,
           AW'($urandom_range(0, 7)));
    end

    repeat (4) @(posedge clk);
    #2;
    totalCnt++;
    if (expQ.size() == 0) passCnt++;
    else $display("FAIL drain: %0d left expected 0", expQ.size());
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
